// File: rtl/game_ctrl.sv
// game_ctrl: three-trial reaction game round sequencer
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - begin a round (accepted only in IDLE)
//   hit    - one-cycle player press pulse
//   target - target LED, high during the response window
//   score  - hits in current/last round (0..3)
//   en     - result display enable, high during the show interval
//   busy   - high from round start until return to IDLE
//   done   - one-cycle pulse when the show interval ends
module game_ctrl #(
  parameter int unsigned ARM_TICKS  = 100_000_000,
  parameter int unsigned WIN_TICKS  = 30_000_000,
  parameter int unsigned GAP_TICKS  = 50_000_000,
  parameter int unsigned SHOW_TICKS = 300_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  output logic       target,
  output logic [1:0] score,
  output logic       en,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, ARM, WINDOW, GAP, SHOW} state_t;
  state_t      state, state_n;
  logic [31:0] timer, timer_n;
  logic [1:0]  trial, trial_n, score_n;
  logic        foul, foul_n, target_n, en_n, busy_n, done_n;
  logic        arm_end, win_end, gap_end, show_end, last_trial, early;
  assign arm_end    = timer == 32'(ARM_TICKS - 1);
  assign win_end    = timer == 32'(WIN_TICKS - 1);
  assign gap_end    = timer == 32'(GAP_TICKS - 1);
  assign show_end   = timer == 32'(SHOW_TICKS - 1);
  assign last_trial = trial == 2'd2;
  // a press on the final ARM cycle still disqualifies the trial
  assign early      = foul || hit;
  always_comb begin
    state_n  = state;
    timer_n  = timer + 32'd1;
    trial_n  = trial;
    score_n  = score;
    foul_n   = foul;
    target_n = target;
    en_n     = en;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = ARM;
        score_n = 2'd0;
        trial_n = 2'd0;
        foul_n  = 1'b0;
        busy_n  = 1'b1;
      end
      ARM: begin
        foul_n = early;
        if (arm_end) begin
          state_n  = early ? GAP : WINDOW;
          target_n = !early;
        end
      end
      WINDOW: if (hit || win_end) begin
        state_n  = GAP;
        target_n = 1'b0;
        score_n  = score + {1'b0, hit};
      end
      GAP: if (gap_end) begin
        state_n = last_trial ? SHOW : ARM;
        en_n    = last_trial;
        trial_n = last_trial ? trial : trial + 2'd1;
        foul_n  = last_trial ? foul : 1'b0;
      end
      SHOW: if (show_end) begin
        state_n = IDLE;
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // timer restarts from 0 on entry to every state and rests at 0 in IDLE
    if (state_n != state || state == IDLE)
      timer_n = 32'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= 32'd0;
      trial  <= 2'd0;
      foul   <= 1'b0;
      score  <= 2'd0;
      target <= 1'b0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      trial  <= trial_n;
      foul   <= foul_n;
      score  <= score_n;
      target <= target_n;
      en     <= en_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end
  // score increments at most once per trial, so it can never wrap past 3
  assert property (@(posedge clk) disable iff (!reset)
    !(state == WINDOW && hit && score == 2'd3));
endmodule
